ui_call_ctrl: RTL

UI_CALL_CTRL -- requirements
Module: ui_call_ctrl

---
 rtl/ui_pkg.sv | 68 ++++++
 rtl/ui_menu_nav.sv | 83 ++++++++
 rtl/ui_call_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ui_pkg.sv
// Shared encodings for the phone UI: call states, application commands,
// menu item indices and the button-priority / menu-tree helpers.
package ui_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_OUTGOING = 3'd2,
    ST_INCOMING = 3'd3,
    ST_BUSY     = 3'd4,
    ST_WAITING  = 3'd5
  } call_state_e;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_CALL   = 3'd1,
    CMD_ANSWER = 3'd2,
    CMD_REJECT = 3'd3,
    CMD_HANGUP = 3'd4,
    CMD_SWAP   = 3'd5,
    CMD_TO_VM  = 3'd6
  } cmd_e;

  typedef enum logic [2:0] {
    BTN_NONE, BTN_UP, BTN_DOWN, BTN_RIGHT, BTN_LEFT, BTN_ENTER
  } btn_e;

  // Top level 0..6, each followed in index order by its submenu (7..15).
  localparam logic [3:0] MI_CALL         = 4'd0;
  localparam logic [3:0] MI_VOLUME       = 4'd1;
  localparam logic [3:0] MI_VOICEMAIL    = 4'd2;
  localparam logic [3:0] MI_BLOCK        = 4'd3;
  localparam logic [3:0] MI_FWD          = 4'd4;
  localparam logic [3:0] MI_GET_NUM      = 4'd5;
  localparam logic [3:0] MI_SET_TIME     = 4'd6;
  localparam logic [3:0] MI_TOP_LAST     = 4'd6;
  localparam logic [3:0] MI_DIAL         = 4'd7;
  localparam logic [3:0] MI_VOL_ADJ      = 4'd8;
  localparam logic [3:0] MI_VM_TOGGLE    = 4'd9;
  localparam logic [3:0] MI_BLOCK_TOGGLE = 4'd10;
  localparam logic [3:0] MI_FWD_TOGGLE   = 4'd11;
  localparam logic [3:0] MI_SHOW_NUM     = 4'd12;
  localparam logic [3:0] MI_TIME_HH      = 4'd13;
  localparam logic [3:0] MI_TIME_MM      = 4'd14;
  localparam logic [3:0] MI_TIME_SS      = 4'd15;

  function automatic btn_e pick_btn(input logic up, down, right, left, enter);
    if (up)    return BTN_UP;
    if (down)  return BTN_DOWN;
    if (right) return BTN_RIGHT;
    if (left)  return BTN_LEFT;
    if (enter) return BTN_ENTER;
    return BTN_NONE;
  endfunction

  function automatic logic [3:0] sub_first(input logic [3:0] top);
    return (top > MI_TOP_LAST) ? top : top + 4'd7;
  endfunction

  function automatic logic [3:0] sub_last(input logic [3:0] top);
    return (top == MI_SET_TIME) ? MI_TIME_SS : sub_first(top);
  endfunction

  function automatic logic [3:0] parent_of(input logic [3:0] item);
    return (item >= MI_TIME_HH) ? MI_SET_TIME : item - 4'd7;
  endfunction

endpackage

// File: rtl/ui_menu_nav.sv
// Two-level menu cursor plus the settings it owns (volume, feature toggles).
// Raises dial_req combinationally when enter lands on a dial item.
module ui_menu_nav
  import ui_pkg::*;
#(
  parameter int VOL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             allow_enter,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             enter,
  output logic [3:0]       menu_item,
  output logic [VOL_W-1:0] volume,
  output logic             vm_en,
  output logic             block_en,
  output logic             fwd_en,
  output logic             dial_req
);

  localparam logic [VOL_W-1:0] VOL_MAX = '1;
  localparam logic [VOL_W-1:0] VOL_RST = {1'b1, {(VOL_W-1){1'b0}}};

  btn_e       btn;
  logic       at_top;
  logic [3:0] first;
  logic [3:0] last;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    btn      = active ? pick_btn(up, down, right, left, enter) : BTN_NONE;
    at_top   = (menu_item <= MI_TOP_LAST);
    first    = at_top ? MI_CALL     : sub_first(parent_of(menu_item));
    last     = at_top ? MI_TOP_LAST : sub_last(parent_of(menu_item));
    dial_req = 1'b0;
    if (btn == BTN_ENTER && allow_enter &&
        (menu_item == MI_CALL || menu_item == MI_DIAL))
      dial_req = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      menu_item <= MI_CALL;
      volume    <= VOL_RST;
      vm_en     <= 1'b0;
      block_en  <= 1'b0;
      fwd_en    <= 1'b0;
    end else begin
      case (btn)
        BTN_UP:
          if (menu_item == MI_VOL_ADJ) begin
            if (volume != VOL_MAX) volume <= volume + VOL_W'(1);
          end else begin
            menu_item <= (menu_item == first) ? last : menu_item - 4'd1;
          end
        BTN_DOWN:
          if (menu_item == MI_VOL_ADJ) begin
            if (volume != '0) volume <= volume - VOL_W'(1);
          end else begin
            menu_item <= (menu_item == last) ? first : menu_item + 4'd1;
          end
        BTN_RIGHT: if (at_top)  menu_item <= sub_first(menu_item);
        BTN_LEFT:  if (!at_top) menu_item <= parent_of(menu_item);
        BTN_ENTER:
          if (allow_enter) begin
            case (menu_item)
              MI_VM_TOGGLE:    vm_en    <= ~vm_en;
              MI_BLOCK_TOGGLE: block_en <= ~block_en;
              MI_FWD_TOGGLE:   fwd_en   <= ~fwd_en;
              default: ;
            endcase
          end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ui_call_ctrl.sv
// Call-control FSM for the phone UI: ring timeouts, call-waiting, and a
// single-slot valid/ready command port towards the application layer.
module ui_call_ctrl
  import ui_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter int          VOL_W   = 4,
  parameter logic [31:0] RING_TO = 32'd270000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic              enter,
  input  logic [ADDR_W-1:0] sw,
  input  logic              inc_call,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              connected,
  input  logic              ended,
  output logic              cmd_valid,
  output logic [2:0]        cmd,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ready,
  output logic [2:0]        state,
  output logic [3:0]        menu_item,
  output logic [VOL_W-1:0]  volume,
  output logic              vm_en,
  output logic              block_en,
  output logic              fwd_en,
  output logic [ADDR_W-1:0] peer_addr
);

  call_state_e       cs, ns;
  cmd_e              cmd_q, issue_cmd;
  logic              issue, free, timeout, dial_req, left_p, enter_p;
  logic [ADDR_W-1:0] issue_addr, peer_nxt, held_q, held_nxt;
  logic [31:0]       ring_cnt;
  btn_e              btn;

  ui_menu_nav #(.VOL_W(VOL_W)) u_nav (
    .clk        (clk),
    .reset      (reset),
    .active     (cs != ST_INIT),
    .allow_enter(cs == ST_IDLE || cs == ST_BUSY),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .enter      (enter),
    .menu_item  (menu_item),
    .volume     (volume),
    .vm_en      (vm_en),
    .block_en   (block_en),
    .fwd_en     (fwd_en),
    .dial_req   (dial_req)
  );

  assign btn     = pick_btn(up, down, right, left, enter);
  assign left_p  = (btn == BTN_LEFT);
  assign enter_p = (btn == BTN_ENTER);
  assign free    = ~cmd_valid;
  assign timeout = (ring_cnt == RING_TO - 32'd1);
  assign state   = cs;
  assign cmd     = cmd_q;

  // Button actions that need the port are skipped entirely while it is busy;
  // timeouts and remote events still move the state, their command is dropped.
  always_comb begin
    ns         = cs;
    issue      = 1'b0;
    issue_cmd  = CMD_NONE;
    issue_addr = peer_addr;
    peer_nxt   = peer_addr;
    held_nxt   = held_q;
    case (cs)
      ST_INIT: if (enter_p) ns = ST_IDLE;
      ST_IDLE:
        if (inc_call) begin
          if (block_en) begin
            issue = 1'b1; issue_cmd = CMD_REJECT; issue_addr = inc_addr;
          end else begin
            peer_nxt = inc_addr; ns = ST_INCOMING;
          end
        end else if (dial_req && free) begin
          issue = 1'b1; issue_cmd = CMD_CALL; issue_addr = sw;
          peer_nxt = sw; ns = ST_OUTGOING;
        end
      ST_OUTGOING:
        if (ended)                 ns = ST_IDLE;
        else if (connected)        ns = ST_BUSY;
        else if (timeout || (left_p && free)) begin
          issue = 1'b1; issue_cmd = CMD_HANGUP; ns = ST_IDLE;
        end else if (inc_call) begin
          issue = 1'b1; issue_cmd = CMD_REJECT; issue_addr = inc_addr;
        end
      ST_INCOMING:
        if (ended) ns = ST_IDLE;
        else if (timeout) begin
          issue = 1'b1; issue_cmd = vm_en ? CMD_TO_VM : CMD_REJECT; ns = ST_IDLE;
        end else if (enter_p && free) begin
          issue = 1'b1; issue_cmd = CMD_ANSWER; ns = ST_BUSY;
        end else if (left_p && free) begin
          issue = 1'b1; issue_cmd = CMD_REJECT; ns = ST_IDLE;
        end else if (inc_call) begin
          issue = 1'b1; issue_cmd = CMD_REJECT; issue_addr = inc_addr;
        end
      ST_BUSY:
        if (ended) ns = ST_IDLE;
        else if (left_p && free) begin
          issue = 1'b1; issue_cmd = CMD_HANGUP; ns = ST_IDLE;
        end else if (inc_call) begin
          if (block_en) begin
            issue = 1'b1; issue_cmd = CMD_REJECT; issue_addr = inc_addr;
          end else begin
            held_nxt = inc_addr; ns = ST_WAITING;
          end
        end
      ST_WAITING:
        if (ended) ns = ST_IDLE;
        else if (enter_p && free) begin
          issue = 1'b1; issue_cmd = CMD_SWAP; issue_addr = held_q;
          peer_nxt = held_q; ns = ST_BUSY;
        end else if (left_p && free) begin
          issue = 1'b1; issue_cmd = CMD_REJECT; issue_addr = held_q; ns = ST_BUSY;
        end else if (inc_call) begin
          issue = 1'b1; issue_cmd = CMD_REJECT; issue_addr = inc_addr;
        end
      default: ns = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cs        <= ST_INIT;
      peer_addr <= '0;
      held_q    <= '0;
      ring_cnt  <= '0;
      cmd_valid <= 1'b0;
      cmd_q     <= CMD_NONE;
      cmd_addr  <= '0;
    end else begin
      cs        <= ns;
      peer_addr <= peer_nxt;
      held_q    <= held_nxt;
      if (ns != cs || !(cs == ST_OUTGOING || cs == ST_INCOMING))
        ring_cnt <= '0;
      else
        ring_cnt <= ring_cnt + 32'd1;
      if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
        cmd_q     <= CMD_NONE;
      end else if (issue && free) begin
        cmd_valid <= 1'b1;
        cmd_q     <= issue_cmd;
        cmd_addr  <= issue_addr;
      end
    end
  end

endmodule
